zbt_arbiter: RTL
================

Name: zbt_arbiter

Overview:
Shares one pipelined ZBT SRAM between two requesters: port A (read-only, high priority, e.g. video scan-out) and port B (read/write, e.g. frame capture or processing). It accepts at most one request per cycle and drives registered RAM control, address and write data with ZBT two-cycle data timing. Read data is returned to the requester that issued the read. The block runs on the deskewed FPGA clock; its reset is held asserted until the RAM clock DCMs report lock.

Parameters:
AW, 19, RAM address width
DW, 36, RAM data width
STARVE_MAX, 8, max consecutive cycles port B may lose arbitration while requesting; range 1..255

Ports:
clk  in  1  deskewed FPGA clock, same phase as RAM clock
reset_n  in  1  asynchronous, active-low reset
a_req  in  1  port A read request
a_addr  in  AW  port A read address
a_gnt  out  1  port A request accepted this cycle (combinational)
a_rd_data  out  DW  port A read data
a_rd_valid  out  1  a_rd_data valid, one-cycle pulse per read
b_req  in  1  port B request
b_we  in  1  1 = write, 0 = read
b_addr  in  AW  port B address
b_wdata  in  DW  port B write data, sampled at accept
b_gnt  out  1  port B request accepted this cycle (combinational)
b_rd_data  out  DW  port B read data
b_rd_valid  out  1  b_rd_data valid, one-cycle pulse per read
ram_addr  out  AW  registered RAM address
ram_cen_b  out  1  registered chip enable, active low
ram_we_b  out  1  registered write enable, active low
ram_data_out  out  DW  registered write data
ram_data_oe  out  1  registered output enable for the bidirectional data bus
ram_data_in  in  DW  data from the RAM bus

Behaviour:
- Accept: cycle N with req && gnt. Exactly one of a_gnt/b_gnt is high when either req is high. Both are 0 when neither req is high or while reset_n = 0.
- Arbitration: A wins by default. B wins when only B requests, or when starve_cnt == STARVE_MAX.
- starve_cnt: increments when b_req=1 and A is granted. Clears when B is granted or b_req=0. Saturates at STARVE_MAX.
- Command cycle N+1: ram_addr = accepted addr, ram_cen_b=0, ram_we_b = ~(B && b_we). With no accept in N, ram_cen_b=1 and ram_we_b=1 in N+1; ram_addr holds its previous value.
- Write data cycle N+3: ram_data_out = b_wdata captured at N, ram_data_oe=1. ram_data_oe=0 in every cycle that is not a write-data cycle.
- Read data cycle N+3: ram_data_in is sampled at the end of N+3. In N+4 the owner's rd_data takes the sampled value and its rd_valid pulses for one cycle. Read latency is 4 cycles from accept.
- rd_data holds its value between pulses.
- Pipeline: a 3-stage tag shift register {valid, owner, we} plus a 2-stage write-data pipe. Full throughput: one access per cycle, any mix of reads and writes, no turnaround bubbles. Results return in issue order.
- Read-after-write to the same address in consecutive accepts returns the new data (ZBT guarantees this; no hazard logic).
- Reset (async assert, sync-safe deassert done upstream):
  - RAM outputs: ram_cen_b=1, ram_we_b=1, ram_data_oe=0, ram_addr=0, ram_data_out=0.
  - Read returns and counter: rd_valid=0, rd_data=0, starve_cnt=0.
  - The tag pipeline is cleared. Operations in flight are dropped: no rd_valid pulses and no oe after release for accepts made before reset.
- Grants are never issued while reset_n=0, even if req=1.

Test Plan:
- A read: a_addr=0x00010, accept at N -> N+1: ram_addr=0x00010, cen_b=0, we_b=1. Drive ram_data_in=0x123456789 in N+3 -> N+4: a_rd_valid=1, a_rd_data=0x123456789; b_rd_valid stays 0.
- B write: b_addr=0x7FFFF, b_wdata=0xABCDEF012 -> N+1: we_b=0, cen_b=0. N+3 only: oe=1, ram_data_out=0xABCDEF012. oe=0 in N+2 and N+4.
- Contention, STARVE_MAX=8, a_req=b_req=1 held -> grant pattern repeats 8xA then 1xB. b_gnt never low for more than 8 consecutive cycles.
- Back-to-back B write 0x55 / read / write 0xAA / read to addr 0x100 against a ZBT behavioural model -> no idle command cycles; reads return 0x55 and 0xAA in order; oe never asserted in a read-data cycle.
- Reset mid-flight: accept A read at N, pull reset_n low in N+2 -> all outputs go to reset values immediately. After release, no a_rd_valid; a new read completes with 4-cycle latency.
- Idle: no requests for 10 cycles -> ram_cen_b=1, ram_we_b=1, oe=0, no grants, no rd_valid.

Source files
------------

// File: rtl/zbt_arbiter.sv
// zbt_arbiter: two-port arbiter for one pipelined ZBT SRAM.
// Port A reads at high priority; port B reads/writes with a starvation bound.
module zbt_arbiter #(
  parameter int AW = 19,
  parameter int DW = 36,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic [DW-1:0] a_rd_data,
  output logic          a_rd_valid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rd_data,
  output logic          b_rd_valid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_cen_b,
  output logic          ram_we_b,
  output logic [DW-1:0] ram_data_out,
  output logic          ram_data_oe,
  input  logic [DW-1:0] ram_data_in
);

  logic [7:0]    starve_cnt;
  logic          starved;
  logic          acc;
  logic          b_wr;
  logic [2:0]    t_v;
  logic [2:0]    t_b;
  logic [2:0]    t_w;
  logic [DW-1:0] wd1;
  logic [DW-1:0] wd2;
  logic          wr_data;
  logic          rd_ret;

  assign starved = (starve_cnt == 8'(STARVE_MAX));
  assign b_gnt   = reset_n & b_req & (~a_req | starved);
  assign a_gnt   = reset_n & a_req & ~b_gnt;
  assign acc     = a_gnt | b_gnt;
  assign b_wr    = b_gnt & b_we;

  // stage index 0/1/2 = command / gap / data cycle
  assign wr_data = t_v[1] & t_w[1];
  assign rd_ret  = t_v[2] & ~t_w[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (b_req & a_gnt) begin
      if (!starved) starve_cnt <= starve_cnt + 8'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_cen_b <= 1'b1;
      ram_we_b  <= 1'b1;
    end else begin
      ram_cen_b <= ~acc;
      ram_we_b  <= ~b_wr;
      if (acc) ram_addr <= b_gnt ? b_addr : a_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_v <= '0;
      t_b <= '0;
      t_w <= '0;
      wd1 <= '0;
      wd2 <= '0;
    end else begin
      t_v <= {t_v[1:0], acc};
      t_b <= {t_b[1:0], b_gnt};
      t_w <= {t_w[1:0], b_wr};
      wd1 <= b_wdata;
      wd2 <= wd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_data_oe  <= 1'b0;
      ram_data_out <= '0;
    end else begin
      ram_data_oe <= wr_data;
      if (wr_data) ram_data_out <= wd2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rd_valid <= 1'b0;
      b_rd_valid <= 1'b0;
      a_rd_data  <= '0;
      b_rd_data  <= '0;
    end else begin
      a_rd_valid <= rd_ret & ~t_b[2];
      b_rd_valid <= rd_ret & t_b[2];
      if (rd_ret & ~t_b[2]) a_rd_data <= ram_data_in;
      if (rd_ret & t_b[2])  b_rd_data <= ram_data_in;
    end
  end

endmodule
